// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave in front of a byte-addressable register file.
// AW and W are captured independently into holding registers. A write commits
// once both are held, user logic is ready and no B response is outstanding.
// Reads are registered and held stable while the master backpressures R.
// User logic sees AXI writes on the commit strobe and can overwrite whole
// words through the update port, which wins over a same-index AXI commit.
module axi4_lite_regfile #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH),
    localparam int unsigned IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [STRB_WIDTH-1:0]     wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    input  logic                      user_ready,
    output logic                      write_en,
    output logic [IDX_WIDTH-1:0]      write_addr,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic [STRB_WIDTH-1:0]     write_strb,
    input  logic                      update_valid,
    input  logic [IDX_WIDTH-1:0]      update_addr,
    input  logic [DATA_WIDTH-1:0]     update_data
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A = AXI_ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Address decode: offset from the window base, word index from the offset.
    logic [AXI_ADDR_WIDTH-1:0] aw_off, ar_off;
    logic                      aw_in_range, ar_in_range;
    logic [IDX_WIDTH-1:0]      aw_idx, ar_idx;

    assign aw_off      = awaddr - BASE_ADDR;
    assign ar_off      = araddr - BASE_ADDR;
    assign aw_in_range = (awaddr >= BASE_ADDR) && ((aw_off >> ADDR_LSB) < DEPTH_A);
    assign ar_in_range = (araddr >= BASE_ADDR) && ((ar_off >> ADDR_LSB) < DEPTH_A);
    assign aw_idx      = aw_off[ADDR_LSB +: IDX_WIDTH];
    assign ar_idx      = ar_off[ADDR_LSB +: IDX_WIDTH];

    // Holding registers for the write channels.
    logic                  aw_full, aw_ok, w_full;
    logic [IDX_WIDTH-1:0]  aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  commit;

    assign awready = rst_n & ~aw_full;
    assign wready  = rst_n & ~w_full;
    assign commit  = aw_full & w_full & user_ready & ~bvalid;

    assign write_en   = commit & aw_ok;
    assign write_addr = aw_idx_q;
    assign write_data = w_data_q;
    assign write_strb = w_strb_q;

    // Capture AW on handshake and release it on commit.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full  <= 1'b0;
            aw_ok    <= 1'b0;
            aw_idx_q <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
        end else if (awvalid && awready) begin
            aw_full  <= 1'b1;
            aw_ok    <= aw_in_range;
            aw_idx_q <= aw_idx;
        end
    end

    // Capture W on handshake and release it on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_full   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            w_full <= 1'b0;
        end else if (wvalid && wready) begin
            w_full   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
        end
    end

    // Write response: raised the cycle after commit, held until bready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bready) begin
            bvalid <= 1'b0;
        end
    end

    // Storage array: byte-strobed AXI commit, then the user update, which
    // overrides all bytes when both target the same word.
    // NOTE: the array has no reset; contents are undefined until written,
    // which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb_q[b]) begin
                    mem[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
        if (update_valid) begin
            mem[update_addr] <= update_data;
        end
    end

    // Registered read; sampling mem at the same edge as a write gives read-first.
    logic ar_hs;
    assign arready = rst_n & (~rvalid | rready);
    assign ar_hs   = arvalid & arready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata  <= ar_in_range ? mem[ar_idx] : '0;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

    // Protection bits and upper offset bits carry no meaning here.
    logic unused;
    assign unused = ^{awprot, arprot, aw_off, ar_off};

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Self-checking bench for axi4_lite_regfile: directed scenarios followed by
// randomized AXI writes, reads and user updates against a word-array model.
module tb_axi4_lite_regfile;

    localparam int          DW    = 32;
    localparam int          DEPTH = 16;
    localparam int          IW    = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   awaddr = '0, araddr = '0;
    logic [2:0]    awprot = '0, arprot = '0;
    logic          awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [DW-1:0] wdata = '0, rdata;
    logic [3:0]    wstrb = '0;
    logic [1:0]    bresp, rresp;
    logic          user_ready = 1, write_en;
    logic [IW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [3:0]    write_strb;
    logic          update_valid = 0;
    logic [IW-1:0] update_addr = '0;
    logic [DW-1:0] update_data = '0;

    axi4_lite_regfile #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AXI_ADDR_WIDTH(32), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .user_ready(user_ready), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .write_strb(write_strb),
        .update_valid(update_valid), .update_addr(update_addr), .update_data(update_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2) % DEPTH;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) return BASE - 32'(4 * $urandom_range(1, 8));
            return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 31));
        end
        return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
    endfunction

    // Drive at posedge+1, sample at negedge.
    task automatic to_pos(); @(posedge clk); #1; endtask
    task automatic to_neg(); @(negedge clk); endtask

    task automatic do_reset();
        rst_n = 0;
        to_neg();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_write_en", write_en, 0);
        to_pos();
        rst_n = 1;
    endtask

    task automatic upd(input int idx, input logic [31:0] data);
        update_valid = 1;
        update_addr  = IW'(idx);
        update_data  = data;
        to_pos();
        update_valid = 0;
        model[idx]   = data;
    endtask

    // One AXI write with W/AW start delays and extra user_ready stall cycles.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int stall);
        bit ok = in_rng(addr);
        int idx = ok ? idx_of(addr) : 0;
        int last = (aw_dly > w_dly) ? aw_dly : w_dly;
        int aw_t = -1, w_t = -1, en_cnt = 0, en_t = -1, b_t = -1;
        logic [1:0] resp = 2'bxx;
        for (int t = 0; t < 60 && b_t < 0; t++) begin
            awvalid    = (aw_t < 0) && (t >= aw_dly);
            awaddr     = addr;
            wvalid     = (w_t < 0) && (t >= w_dly);
            wdata      = data;
            wstrb      = strb;
            user_ready = (t >= last + 1 + stall);
            bready     = 1;
            to_neg();
            if (awvalid && awready) aw_t = t;
            if (wvalid && wready) w_t = t;
            if (write_en) begin
                en_cnt++;
                en_t = t;
                check("wr_addr", write_addr, idx);
                check("wr_data", write_data, data);
                check("wr_strb", write_strb, strb);
            end
            if (bvalid) begin
                b_t  = t;
                resp = bresp;
            end
            to_pos();
        end
        awvalid = 0; wvalid = 0; user_ready = 1;
        check("aw_cycle", aw_t, aw_dly);
        check("w_cycle", w_t, w_dly);
        check("wen_count", en_cnt, ok);
        if (ok) check("wen_cycle", en_t, last + 1 + stall);
        check("b_cycle", b_t, last + 2 + stall);
        check("bresp", resp, ok ? 2'b00 : 2'b10);
        if (ok) model[idx] = merge(model[idx], data, strb);
    endtask

    task automatic axi_read(input logic [31:0] addr);
        bit ok = in_rng(addr);
        logic [31:0] exp = ok ? model[idx_of(addr)] : 32'h0;
        arvalid = 1; araddr = addr; rready = 1;
        to_neg();
        check("rd_arready", arready, 1);
        to_pos();
        arvalid = 0;
        to_neg();
        check("rd_rvalid", rvalid, 1);
        check("rd_rdata", rdata, exp);
        check("rd_rresp", rresp, ok ? 2'b00 : 2'b10);
        to_pos();
        to_neg();
        check("rd_rvalid_drop", rvalid, 0);
        to_pos();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0;
        to_pos();
        do_reset();
        for (int i = 0; i < DEPTH; i++) upd(i, $urandom);

        // Basic write then read at word 2.
        axi_write(32'h1008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read(32'h1008);

        // W three cycles ahead of AW, bready low four cycles, second write queued.
        bready = 0;
        wvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        to_neg(); check("w_first_wready", wready, 1); to_pos();
        wvalid = 0;
        for (int i = 0; i < 2; i++) begin
            to_neg(); check("w_held_wready", wready, 0); check("w_held_wen", write_en, 0); to_pos();
        end
        awvalid = 1; awaddr = 32'h100C;
        to_neg(); check("aw_late_awready", awready, 1); check("aw_late_wen", write_en, 0); to_pos();
        awvalid = 0;
        to_neg();
        check("late_wen", write_en, 1); check("late_waddr", write_addr, 3);
        check("late_wdata", write_data, 32'hCAFE_F00D); check("late_bvalid", bvalid, 0);
        to_pos();
        model[3] = 32'hCAFE_F00D;
        awvalid = 1; awaddr = 32'h1010; wvalid = 1; wdata = 32'h0BAD_F00D;
        to_neg(); check("q2_awready", awready, 1); check("q2_wready", wready, 1); to_pos();
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bready = 1;
            to_neg();
            check("bhold_bvalid", bvalid, 1); check("bhold_bresp", bresp, 0);
            check("bhold_wen", write_en, 0);
            to_pos();
        end
        to_neg();
        check("q2_bvalid_low", bvalid, 0); check("q2_wen", write_en, 1); check("q2_waddr", write_addr, 4);
        to_pos();
        model[4] = 32'h0BAD_F00D;
        to_neg(); check("q2_bvalid", bvalid, 1); check("q2_bresp", bresp, 0); to_pos();
        to_neg(); check("q2_bdone", bvalid, 0); to_pos();
        axi_read(32'h100C);
        axi_read(32'h1010);

        // Byte strobes, including an empty strobe.
        upd(5, 32'h1122_3344);
        axi_write(32'h1014, 32'hAABB_CCDD, 4'b0101, 1, 0, 1);
        axi_read(32'h1014);
        axi_write(32'h1016, 32'hFFFF_FFFF, 4'b0000, 0, 2, 0);
        axi_read(32'h1014);

        // Out-of-range accesses on both sides of the window.
        axi_write(32'h0FFC, 32'h1234_5678, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'(DEPTH * 4), 32'h1234_5678, 4'hF, 0, 0, 0);
        axi_read(32'h0FFC);
        axi_read(BASE + 32'(DEPTH * 4));

        // R backpressure then back-to-back reads.
        arvalid = 1; araddr = BASE + 4; rready = 0;
        to_neg(); check("bp_first_arready", arready, 1); to_pos();
        araddr = BASE + 8;
        for (int i = 0; i < 5; i++) begin
            to_neg();
            check("bp_arready", arready, 0); check("bp_rvalid", rvalid, 1);
            check("bp_rdata", rdata, model[1]);
            to_pos();
        end
        rready = 1;
        for (int k = 2; k <= 6; k++) begin
            to_neg();
            check("b2b_arready", arready, 1); check("b2b_rvalid", rvalid, 1);
            check("b2b_rdata", rdata, model[k - 1]);
            to_pos();
            araddr = BASE + 32'(4 * (k + 1));
            arvalid = (k < 5);
        end
        to_neg(); check("b2b_idle", rvalid, 0); to_pos();

        // AXI commit and update to the same word: update wins.
        awvalid = 1; awaddr = BASE + 28; wvalid = 1; wdata = 32'h1; wstrb = 4'hF;
        to_pos();
        awvalid = 0; wvalid = 0;
        update_valid = 1; update_addr = 7; update_data = 32'h2;
        to_neg(); check("col_wen", write_en, 1); check("col_waddr", write_addr, 7); to_pos();
        update_valid = 0;
        to_neg(); check("col_bvalid", bvalid, 1); check("col_bresp", bresp, 0); to_pos();
        model[7] = 32'h2;
        axi_read(BASE + 28);

        // Commit and update to different words: both land.
        awvalid = 1; awaddr = BASE + 32; wvalid = 1; wdata = 32'h0808; wstrb = 4'hF;
        to_pos();
        awvalid = 0; wvalid = 0;
        update_valid = 1; update_addr = 9; update_data = 32'h0909;
        to_neg(); check("diff_wen", write_en, 1); to_pos();
        update_valid = 0;
        to_pos();
        model[8] = 32'h0808; model[9] = 32'h0909;
        axi_read(BASE + 32);
        axi_read(BASE + 36);

        // Read and update of the same word in one cycle returns the old value.
        arvalid = 1; araddr = BASE + 36;
        update_valid = 1; update_addr = 9; update_data = 32'h9999;
        to_pos();
        arvalid = 0; update_valid = 0;
        to_neg(); check("rf_rdata", rdata, model[9]); to_pos();
        model[9] = 32'h9999;
        axi_read(BASE + 36);

        // Reset with AW held and an R response pending.
        awvalid = 1; awaddr = BASE + 24; arvalid = 1; araddr = BASE + 8; rready = 0;
        to_pos();
        awvalid = 0; arvalid = 0;
        to_neg(); check("pre_rst_awready", awready, 0); check("pre_rst_rvalid", rvalid, 1); to_pos();
        do_reset();
        rready = 1;
        to_neg(); check("post_rst_awready", awready, 1); check("post_rst_rvalid", rvalid, 0); to_pos();
        wvalid = 1; wdata = 32'h5555_AAAA; wstrb = 4'hF;
        to_neg(); check("post_rst_wready", wready, 1); to_pos();
        wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            to_neg(); check("post_rst_wen", write_en, 0); check("post_rst_bvalid", bvalid, 0); to_pos();
        end
        do_reset();
        axi_read(BASE + 24);

        // Randomized mix.
        for (int n = 0; n < 200; n++) begin
            int r = $urandom_range(0, 9);
            if (r < 5)
                axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else if (r < 8)
                axi_read(rand_addr());
            else
                upd($urandom_range(0, DEPTH - 1), $urandom);
        end
        for (int i = 0; i < DEPTH; i++) axi_read(BASE + 32'(4 * i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_regfile.md
Name: axi4_lite_regfile

Overview:
- Parametrised AXI4-Lite slave fronting a byte-addressable register file. Generalises the existing single-width slave with configurable data width, depth and base address.
- Adds byte-strobe writes, SLVERR on out-of-range accesses, and independent AW/W holding registers.
- Read data is registered and held stable under rready backpressure.
- Sits between the AXI interconnect and user logic (e.g. LSTM weight/state storage). User logic mirrors writes via a notify port and overwrites words via an update port.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64 only.
DEPTH, 256, number of DATA_WIDTH words; power of two, ≥2.
AXI_ADDR_WIDTH, 32, width of awaddr/araddr.
BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*DATA_WIDTH/8.
Derived (localparam): STRB_WIDTH=DATA_WIDTH/8, ADDR_LSB=$clog2(STRB_WIDTH), IDX_WIDTH=$clog2(DEPTH).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
awaddr  in  AXI_ADDR_WIDTH  write address
awprot  in  3  ignored
awvalid/awready  in/out  1  AW handshake
wdata  in  DATA_WIDTH  write data
wstrb  in  STRB_WIDTH  byte enables
wvalid/wready  in/out  1  W handshake
bresp  out  2  OKAY=00, SLVERR=10
bvalid/bready  out/in  1  B handshake
araddr  in  AXI_ADDR_WIDTH  read address
arprot  in  3  ignored
arvalid/arready  in/out  1  AR handshake
rdata  out  DATA_WIDTH  read data
rresp  out  2  OKAY/SLVERR
rvalid/rready  out/in  1  R handshake
user_ready  in  1  user logic may accept a write commit
write_en  out  1  one-cycle commit strobe
write_addr  out  IDX_WIDTH  committed word index
write_data  out  DATA_WIDTH  committed data
write_strb  out  STRB_WIDTH  committed strobes
update_valid  in  1  user full-word write
update_addr  in  IDX_WIDTH  user word index
update_data  in  DATA_WIDTH  user data

Behaviour:
- Reset (async assert, sync release):
  - Cleared to 0: aw_full, w_full, bvalid, bresp, rvalid, rresp, rdata, write_en.
  - Forced low while rst_n=0: awready, wready, arready.
  - Array contents are not reset.
  - Reset mid-transaction discards held AW/W and any pending B/R.
- Address decode:
  - off = addr - BASE_ADDR; in_range = (addr ≥ BASE_ADDR) && (off>>ADDR_LSB) < DEPTH.
  - Index = off[ADDR_LSB +: IDX_WIDTH]. Low ADDR_LSB bits are ignored (unaligned is treated as aligned).
- Write path:
  - awready=!aw_full and wready=!w_full. Each channel is captured independently into its holding register; AW and W may arrive in either order or the same cycle.
  - commit = aw_full && w_full && user_ready && !bvalid. Commit happens at the earliest one cycle after the later of the two handshakes.
  - On commit: clear aw_full and w_full; set bvalid next cycle.
    - bresp=00 if in_range, else 10.
    - write_en=in_range (combinational, same cycle as commit), with held index/data/strb on write_addr/write_data/write_strb.
    - Array writes only bytes with strb=1. strb=0 commit is legal, reports OKAY and changes nothing.
  - bvalid/bresp hold until bready. Next commit is possible the cycle after the B handshake.
  - user_ready=0 stalls commit indefinitely; holding registers retain contents.
- Read path:
  - arready = rst_n && (!rvalid || rready).
  - AR handshake in cycle N: rdata/rresp load at edge N+1 and rvalid=1.
    - Out of range: rdata=0, rresp=10.
  - rvalid && rready with a new AR in the same cycle: back-to-back, one read per cycle.
  - rdata/rresp stable while rvalid && !rready.
- Collisions:
  - Read and write (AXI or update) to the same index in the same cycle: read returns the old value (read-first).
  - AXI commit and update_valid to the same index in the same cycle: update wins all bytes.
  - Different indices: both take effect.
  - Update writes are not reported on write_en.

Test Plan:
- DATA_WIDTH=32, BASE_ADDR=0x1000. AW 0x1008 and W 0xDEADBEEF/strb 1111 same cycle → write_en one cycle later with write_addr=2. bvalid next cycle, bresp=00. Read 0x1008 → rdata=0xDEADBEEF, rresp=00, rvalid one cycle after AR.
- W arrives 3 cycles before AW, bready held low 4 cycles → wready low after capture; bvalid stays high with bresp stable; no second commit until the B handshake.
- Word 5 = 0x11223344, write 0xAABBCCDD with strb 0101 → read returns 0x11BB33DD.
- Write/read at 0x0FFC and BASE_ADDR+DEPTH*4 → bresp=10, write_en never asserts, rresp=10, rdata=0.
- rready low 5 cycles with arvalid high → arready low, rdata unchanged. Release rready → back-to-back reads, one rvalid per cycle.
- Same cycle: AXI commit to index 7 (0x1) and update_valid index 7 (0x2) → index 7 reads 0x2. Assert rst_n=0 mid-write with AW held → bvalid=0, aw_full cleared, no write_en after release.
